hack_data_memory: RTL and testbench

//   Data-memory responder for the Hack CPU: services CPU accesses (addressM/outM/writeM) and returns inM.
//   Map: RAM 0x0000-0x3FFF, screen 0x4000-0x5FFF, keyboard register 0x6000, all else unmapped.

---
 rtl/hack_data_memory.sv | 115 +++++++++++
 tb/tb_hack_data_memory.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_data_memory.sv
// Hack CPU data memory: RAM, screen and keyboard register on the CPU bus,
// plus a valid/ready streamer that scans screen words out to a display sink.
module hack_data_memory #(
  parameter int unsigned RAM_WORDS    = 16384,
  parameter logic [14:0] SCREEN_BASE  = 15'h4000,
  parameter int unsigned SCREEN_WORDS = 8192,
  parameter logic [14:0] KBD_ADDR     = 15'h6000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_strobe,
  input  logic        kbd_release,
  input  logic        scan_en,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [12:0] pix_addr,
  output logic        frame_start,
  output logic        bad_access
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [15:0] ram    [RAM_WORDS];
  logic [15:0] screen [SCREEN_WORDS];
  logic [15:0] kbd_reg;
  logic [12:0] scan_ptr;
  state_t      state;

  logic [14:0]       scr_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [12:0]       scr_idx;
  logic              ram_hit;
  logic              scr_hit;
  logic              kbd_hit;
  logic              do_load;

  // Address decode; scr_off wraps below the base, so the >= guard matters
  assign scr_off = addressM - SCREEN_BASE;
  assign ram_idx = RAM_AW'(addressM);
  assign scr_idx = 13'(scr_off);
  assign ram_hit = 32'(addressM) < RAM_WORDS;
  assign scr_hit = (addressM >= SCREEN_BASE) && (32'(scr_off) < SCREEN_WORDS);
  assign kbd_hit = (addressM == KBD_ADDR);

  always_comb begin
    inM = 16'h0000;
    if (ram_hit)      inM = ram[ram_idx];
    else if (scr_hit) inM = screen[scr_idx];
    else if (kbd_hit) inM = kbd_reg;
  end

  // Memory arrays keep their contents across reset
  always_ff @(posedge clk) begin
    if (writeM) begin
      if (ram_hit)      ram[ram_idx]    <= outM;
      else if (scr_hit) screen[scr_idx] <= outM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_reg    <= 16'h0000;
      bad_access <= 1'b0;
    end else begin
      if (kbd_strobe)       kbd_reg <= kbd_code;
      else if (kbd_release) kbd_reg <= 16'h0000;
      if (writeM && !ram_hit && !scr_hit) bad_access <= 1'b1;
    end
  end

  // pix_valid is always high in STREAM, so a transfer there is just pix_ready
  assign do_load = scan_en && ((state == IDLE) || pix_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      scan_ptr    <= 13'd0;
      pix_valid   <= 1'b0;
      pix_data    <= 16'h0000;
      pix_addr    <= 13'd0;
      frame_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pix_valid <= 1'b0;
          if (do_load) state <= STREAM;
        end
        STREAM: begin
          if (pix_ready && !scan_en) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (do_load) begin
        pix_data    <= screen[scan_ptr];
        pix_addr    <= scan_ptr;
        frame_start <= (scan_ptr == 13'd0);
        pix_valid   <= 1'b1;
        scan_ptr    <= (scan_ptr == 13'(SCREEN_WORDS - 1)) ? 13'd0 : scan_ptr + 13'd1;
      end
    end
  end

endmodule

// File: tb/tb_hack_data_memory.sv
// Scoreboard bench for hack_data_memory: stimulus queues expected values,
// a negedge monitor pops and compares direct checks and streamed pixel words.
module tb_hack_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [15:0] kbd_code;
  logic        kbd_strobe;
  logic        kbd_release;
  logic        scan_en;
  logic        pix_ready;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [12:0] pix_addr;
  logic        frame_start;
  logic        bad_access;

  always #5 clk = ~clk;

  hack_data_memory dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .kbd_code(kbd_code), .kbd_strobe(kbd_strobe), .kbd_release(kbd_release),
    .scan_en(scan_en), .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_addr(pix_addr), .frame_start(frame_start), .bad_access(bad_access)
  );

  localparam int S_INM = 0, S_BAD = 1, S_VALID = 2, S_ADDR = 3, S_DATA = 4, S_FS = 5;

  logic [15:0] scr_model [8192];
  string       chk_name [$];
  int          chk_sel  [$];
  logic [15:0] chk_exp  [$];
  logic [29:0] pix_q    [$];
  int          errors = 0;
  int          checks = 0;
  bit          done = 1'b0;
  bit          wait_timeout = 1'b0;

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 3) ^ 16'h5A00;
  endfunction

  function automatic logic [15:0] sig(input int sel);
    case (sel)
      S_INM:   return inM;
      S_BAD:   return {15'd0, bad_access};
      S_VALID: return {15'd0, pix_valid};
      S_ADDR:  return {3'd0, pix_addr};
      S_DATA:  return pix_data;
      default: return {15'd0, frame_start};
    endcase
  endfunction

  task automatic expect_sig(input string name, input int sel, input logic [15:0] exp);
    chk_name.push_back(name);
    chk_sel.push_back(sel);
    chk_exp.push_back(exp);
  endtask

  task automatic push_pix(input int a, input logic [15:0] d);
    logic fs;
    fs = (a == 0) ? 1'b1 : 1'b0;
    pix_q.push_back({fs, 13'(a), d});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sole owner of the check/error counters
  initial begin
    string       n;
    int          s;
    logic [15:0] ex;
    logic [15:0] act;
    logic [29:0] cur;
    logic [29:0] held;
    logic [29:0] e;
    bit          held_v;
    bit          timed_out;
    int          ncyc;
    held_v = 1'b0;
    timed_out = 1'b0;
    held = '0;
    ncyc = 0;
    while (!done && !timed_out) begin
      @(negedge clk);
      ncyc++;
      if (done) begin
      end else if (ncyc > 60000) begin
        checks++;
        errors++;
        timed_out = 1'b1;
        $display("FAIL timeout: ran %0d cycles, required done within 60000", ncyc);
      end else begin
        while (chk_name.size() > 0) begin
          n = chk_name.pop_front();
          s = chk_sel.pop_front();
          ex = chk_exp.pop_front();
          act = sig(s);
          checks++;
          if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, ex);
          end
        end
        cur = {frame_start, pix_addr, pix_data};
        if (pix_valid && held_v) begin
          checks++;
          if (cur !== held) begin
            errors++;
            $display("FAIL stall_hold: got fs/addr/data %h want %h", cur, held);
          end
        end
        held_v = pix_valid && !pix_ready;
        held = cur;
        if (pix_valid && pix_ready) begin
          checks++;
          if (pix_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pixel: got fs/addr/data %h want no transfer", cur);
          end else begin
            e = pix_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL pixel: got fs=%b addr=%0d data=%h want fs=%b addr=%0d data=%h",
                       cur[29], cur[28:16], cur[15:0], e[29], e[28:16], e[15:0]);
            end
          end
        end
      end
    end
    checks++;
    if (pix_q.size() != 0) begin
      errors++;
      $display("FAIL pixels_left: got %0d untransferred words want 0", pix_q.size());
    end
    checks++;
    if (wait_timeout) begin
      errors++;
      $display("FAIL wait_addr100: got timeout want pix_addr 100 reached");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Stimulus
  initial begin
    bit found;
    reset = 1'b1; addressM = 15'h6000; outM = 16'h0; writeM = 1'b0;
    kbd_code = 16'h0; kbd_strobe = 1'b0; kbd_release = 1'b0;
    scan_en = 1'b0; pix_ready = 1'b0;
    cyc();
    expect_sig("rst_pix_valid", S_VALID, 16'h0);
    expect_sig("rst_pix_data", S_DATA, 16'h0);
    expect_sig("rst_pix_addr", S_ADDR, 16'h0);
    expect_sig("rst_frame_start", S_FS, 16'h0);
    expect_sig("rst_bad_access", S_BAD, 16'h0);
    expect_sig("rst_kbd", S_INM, 16'h0);
    cyc();
    reset = 1'b0;

    for (int i = 0; i < 8192; i++) begin
      addressM = 15'(32'h4000 + i);
      outM = pat(i);
      writeM = 1'b1;
      scr_model[i] = pat(i);
      cyc();
    end
    writeM = 1'b0;
    addressM = 15'h5FFF;
    expect_sig("read_scr_last", S_INM, pat(8191));
    cyc();

    // RAM write/read ordering and top word
    addressM = 15'h0010; outM = 16'hBEEF; writeM = 1'b1;
    cyc();
    outM = 16'h1234;
    expect_sig("ram_same_cycle_old", S_INM, 16'hBEEF);
    cyc();
    writeM = 1'b0;
    expect_sig("ram_next_cycle_new", S_INM, 16'h1234);
    cyc();
    addressM = 15'h3FFF; outM = 16'hC0DE; writeM = 1'b1;
    cyc();
    writeM = 1'b0;
    expect_sig("ram_top", S_INM, 16'hC0DE);
    expect_sig("bad_after_good_writes", S_BAD, 16'h0);
    cyc();
    addressM = 15'h4000;
    expect_sig("scr_base_read", S_INM, 16'h5A00);
    cyc();

    // Keyboard register
    addressM = 15'h6000; kbd_code = 16'h0041; kbd_strobe = 1'b1;
    expect_sig("kbd_before_strobe", S_INM, 16'h0);
    cyc();
    kbd_strobe = 1'b0;
    expect_sig("kbd_strobe", S_INM, 16'h0041);
    cyc();
    kbd_code = 16'h0042; kbd_strobe = 1'b1; kbd_release = 1'b1;
    cyc();
    kbd_strobe = 1'b0; kbd_release = 1'b0;
    expect_sig("kbd_strobe_wins", S_INM, 16'h0042);
    cyc();
    kbd_release = 1'b1;
    cyc();
    kbd_release = 1'b0;
    expect_sig("kbd_release", S_INM, 16'h0);
    cyc();
    kbd_code = 16'h0041; kbd_strobe = 1'b1;
    cyc();
    kbd_strobe = 1'b0;

    // Illegal writes
    outM = 16'hFFFF; writeM = 1'b1;
    cyc();
    writeM = 1'b0;
    expect_sig("kbd_write_ignored", S_INM, 16'h0041);
    expect_sig("bad_after_kbd_write", S_BAD, 16'h1);
    cyc();
    addressM = 15'h7000; outM = 16'h1111; writeM = 1'b1;
    cyc();
    writeM = 1'b0;
    expect_sig("unmapped_read", S_INM, 16'h0);
    cyc();
    repeat (3) cyc();
    addressM = 15'h6001;
    expect_sig("unmapped_6001", S_INM, 16'h0);
    expect_sig("bad_sticky", S_BAD, 16'h1);
    cyc();

    // Stream two frames; word 0 is rewritten on the first load edge
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    addressM = 15'h4000;
    expect_sig("bad_cleared", S_BAD, 16'h0);
    expect_sig("scr_survives_reset", S_INM, 16'h5A00);
    cyc();
    for (int i = 0; i < 8192; i++) push_pix(i, scr_model[i]);
    scr_model[0] = 16'hFFFF;
    for (int i = 0; i < 20; i++) push_pix(i, scr_model[i]);
    scan_en = 1'b1; pix_ready = 1'b1; outM = 16'hFFFF; writeM = 1'b1;
    expect_sig("scr_same_cycle_old", S_INM, 16'h5A00);
    cyc();
    writeM = 1'b0;
    expect_sig("scr_next_cycle_new", S_INM, 16'hFFFF);
    repeat (8202) cyc();
    pix_ready = 1'b0;
    expect_sig("stall_addr", S_ADDR, 16'd10);
    repeat (5) cyc();
    pix_ready = 1'b1;
    expect_sig("stall_addr_after", S_ADDR, 16'd10);
    expect_sig("stall_data_after", S_DATA, scr_model[10]);
    repeat (9) cyc();
    expect_sig("addr_before_drop", S_ADDR, 16'd19);
    scan_en = 1'b0;
    cyc();
    expect_sig("idle_valid", S_VALID, 16'h0);
    expect_sig("idle_frame_start", S_FS, 16'h0);
    cyc();
    push_pix(20, scr_model[20]);
    push_pix(21, scr_model[21]);
    scan_en = 1'b1;
    cyc();
    cyc();
    scan_en = 1'b0;
    cyc();
    expect_sig("resume_idle_valid", S_VALID, 16'h0);
    cyc();

    // Reset mid-frame at word 100
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) push_pix(i, scr_model[i]);
    scan_en = 1'b1; pix_ready = 1'b1; addressM = 15'h6000;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      cyc();
      if (pix_valid && pix_addr == 13'd100) found = 1'b1;
    end
    if (!found) wait_timeout = 1'b1;
    reset = 1'b1;
    #1;
    expect_sig("midrst_valid", S_VALID, 16'h0);
    expect_sig("midrst_data", S_DATA, 16'h0);
    expect_sig("midrst_addr", S_ADDR, 16'h0);
    expect_sig("midrst_fs", S_FS, 16'h0);
    expect_sig("midrst_kbd", S_INM, 16'h0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push_pix(i, scr_model[i]);
    repeat (5) cyc();
    expect_sig("restart_addr", S_ADDR, 16'd4);
    scan_en = 1'b0;
    cyc();
    expect_sig("restart_idle", S_VALID, 16'h0);
    cyc();
    done = 1'b1;
  end

endmodule
